elastic_fifo_buffer: RTL and testbench
======================================

Name: elastic_fifo_buffer

Overview:
- Parameterised elastic FIFO placed directly downstream of the elastic multiplexer in each PE input and routing path.
- Registers the selected token and decouples the valid/stop handshake, so long combinational stop chains do not form across the CGRA.
- Uses the same valid/stop protocol as the other elastic modules. A token transfers on a rising clock edge when valid is 1 and stop is 0.

Parameters:
- DATA_WIDTH, 32 (from the shared param.v): token data width.
- DEPTH, 2: number of storage entries. Must be at least 1; non-power-of-two values are legal.
- COUNT_WIDTH, $clog2(DEPTH+1): width of the occupancy output.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- data_input  input  DATA_WIDTH  upstream token data.
- valid_input  input  1  upstream token valid.
- stop_input  output  1  backpressure to upstream; 1 means the FIFO is full.
- data_output  output  DATA_WIDTH  head-of-queue data.
- valid_output  output  1  head of queue valid; 1 means the FIFO is not empty.
- stop_output  input  1  backpressure from downstream.
- count  output  COUNT_WIDTH  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - write_ptr, read_ptr and count are cleared to 0.
  - valid_output=0 and stop_input=0.
  - data_output is don't-care; the implementation drives 0 from the cleared entry.
  - Storage contents are not reset, except that entry 0 reads as 0.
  - Reset asserted mid-transfer discards all stored tokens immediately. No partial push or pop completes.
- Control signals:
  - push = valid_input & ~stop_input.
  - pop = valid_output & ~stop_output.
- Output derivation:
  - stop_input = (count == DEPTH), decoded from registered state only. It has no combinational path from stop_output or valid_input.
  - valid_output = (count != 0), registered state only.
  - data_output = mem[read_ptr].
  - There are no combinational paths from inputs to outputs.
- Latency: a token pushed at edge N appears on valid_output/data_output after edge N. Minimum latency is 1 cycle. There is no empty-bypass path.
- On a clock edge:
  - push: mem[write_ptr] takes data_input; write_ptr advances.
  - pop: read_ptr advances.
  - count becomes count + push - pop.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. Explicit compare is used, not modulo by truncation, so non-power-of-two DEPTH works.
- Full, with downstream not stopping: stop_input=1, so push=0 and the pop proceeds. stop_input falls in the next cycle. Full throughput at full occupancy therefore requires DEPTH≥2.
- Empty with an incoming token: pop=0 and the push proceeds.
- Simultaneous push and pop at 0<count<DEPTH: count is unchanged and both pointers advance in the same edge.
- Ordering: strict FIFO. Tokens are never duplicated or dropped.
- Upstream obligations:
  - While stop_input=1, upstream holds data_input and valid_input stable.
  - The FIFO ignores valid_input while stop_input=1.
- Downstream observation: data_output holds stable while valid_output=1 and stop_output=1.
- DEPTH=1: the block acts as a half-rate register slice. stop_input=1 whenever it holds a token.

Decomposition:
- Shared header param.v holds:
  - DATA_WIDTH (existing).
  - ELASTIC_FIFO_DEPTH as the default depth constant, so PE and router instantiations agree.
- The pointer-increment-with-wrap function belongs in the shared header; read and write pointers both use it.
- No sub-module. The storage array, the two pointers and the counter are all local to elastic_fifo_buffer.

Test Plan:
1. Reset then idle: hold reset_n=0 for 3 cycles, release, keep valid_input=0 → valid_output=0, stop_input=0, count=0 for 5 cycles.
2. Single token: push 0xA5A5_0001 with stop_output=0 → valid_output=1 with data_output=0xA5A5_0001 the cycle after the push. It pops on the next edge and count returns to 0.
3. Fill and backpressure, DEPTH=2: stop_output=1, offer 0x11, 0x22, 0x33 → count=2, stop_input=1. 0x33 is held by upstream, with no push. data_output=0x11. Then release stop_output → output order is 0x11, 0x22, 0x33, with no loss.
4. Streaming: valid_input=1 with values 1..16, stop_output=0 → one token out per cycle after 1-cycle latency, count stays at 1. After 16 values the pointers have wrapped 8 times.
5. Non-power-of-two: DEPTH=3, random valid_input and stop_output with 50% density for 1000 tokens → a scoreboard confirms in-order, lossless delivery. count never exceeds 3; stop_input=1 exactly when count=3.
6. Reset mid-operation: with count=2, assert reset_n=0 asynchronously between edges → valid_output and count clear immediately, without waiting for a clock edge. After release, the old tokens never reappear.

Source files
------------

// File: rtl/elastic_fifo_buffer_pkg.sv
// Shared constants and helpers for the elastic datapath modules.
// Both the PE and router instantiations take their FIFO depth from here, so they always agree.
package elastic_fifo_buffer_pkg;

    localparam int DATA_WIDTH         = 32;
    localparam int ELASTIC_FIFO_DEPTH = 2;

    // Wrap by explicit compare so that non-power-of-two depths work.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/elastic_fifo_buffer.sv
// Elastic FIFO that registers the selected token and breaks the valid/stop chain.
// All outputs are decoded from registered state only.
module elastic_fifo_buffer
    import elastic_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = elastic_fifo_buffer_pkg::DATA_WIDTH,
    parameter int DEPTH       = elastic_fifo_buffer_pkg::ELASTIC_FIFO_DEPTH,
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_WIDTH-1:0]  data_input,
    input  logic                   valid_input,
    output logic                   stop_input,
    output logic [DATA_WIDTH-1:0]  data_output,
    output logic                   valid_output,
    input  logic                   stop_output,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_WIDTH-1:0]  write_ptr;
    logic [PTR_WIDTH-1:0]  read_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push;
    logic                  pop;

    assign stop_input   = (count == COUNT_WIDTH'(DEPTH));
    assign valid_output = (count != '0);
    assign push         = valid_input & ~stop_input;
    assign pop          = valid_output & ~stop_output;
    assign data_output  = mem[read_ptr];

    // Entry 0 is cleared so data_output reads 0 after reset; the rest carry no reset.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [DATA_WIDTH-1:0] word;

        if (i == 0) begin : g_cleared
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    word <= '0;
                end else if (push && (write_ptr == PTR_WIDTH'(i))) begin
                    word <= data_input;
                end
            end
        end else begin : g_plain
            always_ff @(posedge clk) begin
                if (push && (write_ptr == PTR_WIDTH'(i))) begin
                    word <= data_input;
                end
            end
        end

        assign mem[i] = word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                write_ptr <= PTR_WIDTH'(ptr_next(32'(write_ptr), DEPTH));
            end
            if (pop) begin
                read_ptr <= PTR_WIDTH'(ptr_next(32'(read_ptr), DEPTH));
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_fifo_buffer.sv
// Directed and random bench for elastic_fifo_buffer at DEPTH=2 and DEPTH=3,
// checked against a queue model of each FIFO.
module tb_elastic_fifo_buffer;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [31:0] din2, dout2, din3, dout3;
    logic        vin2, sin2, vout2, sout2;
    logic        vin3, sin3, vout3, sout3;
    logic [1:0]  cnt2, cnt3;

    int          total = 0;
    int          bad = 0;
    int          delivered3 = 0;
    int          sent3 = 0;
    bit          acc2, acc3, pop2, pop3;
    logic [31:0] q2[$];
    logic [31:0] q3[$];

    always #5 clk = ~clk;

    elastic_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .data_input(din2), .valid_input(vin2), .stop_input(sin2),
        .data_output(dout2), .valid_output(vout2), .stop_output(sout2),
        .count(cnt2)
    );

    elastic_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .data_input(din3), .valid_input(vin3), .stop_input(sin3),
        .data_output(dout3), .valid_output(vout3), .stop_output(sout3),
        .count(cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven: checks outputs
    // against the models, predicts the coming rising edge, then waits for the next falling edge.
    task automatic step();
        #1;
        chk("count2", 32'(cnt2), 32'(q2.size()));
        chk("valid2", 32'(vout2), 32'(q2.size() != 0));
        chk("stop2", 32'(sin2), 32'(q2.size() == 2));
        if (q2.size() != 0) chk("data2", dout2, q2[0]);
        chk("count3", 32'(cnt3), 32'(q3.size()));
        chk("valid3", 32'(vout3), 32'(q3.size() != 0));
        chk("stop3", 32'(sin3), 32'(q3.size() == 3));
        if (q3.size() != 0) chk("data3", dout3, q3[0]);

        acc2 = vin2 && (q2.size() < 2);
        pop2 = (q2.size() != 0) && !sout2;
        acc3 = vin3 && (q3.size() < 3);
        pop3 = (q3.size() != 0) && !sout3;
        if (pop2) void'(q2.pop_front());
        if (acc2) q2.push_back(din2);
        if (pop3) begin
            void'(q3.pop_front());
            delivered3++;
        end
        if (acc3) q3.push_back(din3);
        @(negedge clk);
    endtask

    // Offer one token to the DEPTH=2 FIFO, holding it until taken or the bound expires.
    task automatic offer2(input logic [31:0] v, input int lim);
        din2 = v;
        vin2 = 1'b1;
        for (int n = 0; n < lim; n++) begin
            step();
            if (acc2) break;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        din2 = '0; vin2 = 1'b0; sout2 = 1'b0;
        din3 = '0; vin3 = 1'b0; sout3 = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid2", 32'(vout2), 32'd0);
        chk("rst_stop2", 32'(sin2), 32'd0);
        chk("rst_count2", 32'(cnt2), 32'd0);
        chk("rst_data2", dout2, 32'd0);
        chk("rst_valid3", 32'(vout3), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        repeat (5) step();

        // Single token with one cycle of latency
        offer2(32'hA5A5_0001, 1);
        vin2 = 1'b0;
        step();
        step();

        // Fill under backpressure; third token stays with upstream until release
        sout2 = 1'b1;
        offer2(32'h11, 3);
        offer2(32'h22, 3);
        offer2(32'h33, 4);
        chk("held_not_taken", 32'(acc2), 32'd0);
        sout2 = 1'b0;
        offer2(32'h33, 4);
        chk("held_taken", 32'(acc2), 32'd1);
        vin2 = 1'b0;
        repeat (4) step();

        // Streaming at full rate
        for (int v = 1; v <= 16; v++) begin
            din2 = 32'(v);
            vin2 = 1'b1;
            step();
        end
        vin2 = 1'b0;
        repeat (2) step();

        // Random traffic on the DEPTH=3 FIFO
        acc3 = 1'b0;
        for (int cyc = 0; cyc < 8000 && delivered3 < 1000; cyc++) begin
            if (vin3 && acc3) sent3++;
            if (!vin3 || acc3) begin
                vin3 = (sent3 < 1000) && ($urandom_range(1) == 1);
                din3 = $urandom;
            end
            sout3 = ($urandom_range(1) == 1);
            step();
        end
        vin3 = 1'b0;
        sout3 = 1'b0;
        chk("delivered3", 32'(delivered3), 32'd1000);

        // Asynchronous reset with two tokens stored
        sout2 = 1'b1;
        offer2(32'hDEAD_0001, 3);
        offer2(32'hDEAD_0002, 3);
        vin2 = 1'b0;
        chk("pre_rst_count2", 32'(cnt2), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid2", 32'(vout2), 32'd0);
        chk("async_count2", 32'(cnt2), 32'd0);
        chk("async_stop2", 32'(sin2), 32'd0);
        q2.delete();
        q3.delete();
        @(negedge clk);
        reset_n = 1'b1;
        sout2 = 1'b0;
        repeat (3) step();
        offer2(32'hBEEF_0003, 3);
        vin2 = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
